// File: rtl/multi_chain_scan_ctrl_if.sv
// Bit-parallel stream bundle between the scan controller and its data source/sink.
// The master side is the controller: it consumes in_* and produces out_*.
interface multi_chain_scan_ctrl_if #(
  parameter int NUM_CHAINS = 4
);
  logic [NUM_CHAINS-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_CHAINS-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/multi_chain_scan_ctrl.sv
// Shifts NUM_CHAINS parallel scan chains by a programmed length, streaming the captured
// bits out and, in swap mode, streaming replacement bits in from the input stream.
module multi_chain_scan_ctrl #(
  parameter int NUM_CHAINS = 4,
  parameter int LEN_W      = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [LEN_W-1:0]      cfg_length,
  input  logic                  cfg_mode,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      shift_count,
  multi_chain_scan_ctrl_if.master strm,
  output logic                  scan_enable,
  output logic                  scan_ck_enable,
  output logic [NUM_CHAINS-1:0] scan_input,
  input  logic [NUM_CHAINS-1:0] scan_output
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state_reg;
  logic [LEN_W-1:0]      length_reg;
  logic [LEN_W-1:0]      count_reg;
  logic                  mode_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  scan_enable_reg;
  logic                  out_valid_reg;
  logic [NUM_CHAINS-1:0] out_data_reg;

  logic                  fire;
  logic                  last_shift;
  logic                  out_valid_next;
  logic                  drain_empty;

  // A shift happens only when both streams can take part; abort suppresses it outright.
  assign fire = (state_reg == SHIFT) && !abort
              && (!mode_reg || strm.in_valid)
              && (!out_valid_reg || strm.out_ready);

  assign last_shift     = fire && (count_reg == (length_reg - LEN_W'(1)));
  assign out_valid_next = fire ? 1'b1 : (out_valid_reg && !strm.out_ready);
  // The pending beat leaves this cycle, so DRAIN need not idle an extra cycle.
  assign drain_empty    = !out_valid_reg || strm.out_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg       <= IDLE;
      length_reg      <= '0;
      count_reg       <= '0;
      mode_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      scan_enable_reg <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
    end else begin
      done_reg      <= 1'b0;
      out_valid_reg <= out_valid_next;
      if (fire) begin
        out_data_reg <= scan_output;
        if (count_reg != '1) begin
          count_reg <= count_reg + LEN_W'(1);
        end
      end

      if (busy_reg && abort) begin
        state_reg       <= IDLE;
        busy_reg        <= 1'b0;
        scan_enable_reg <= 1'b0;
        out_valid_reg   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              length_reg <= cfg_length;
              mode_reg   <= cfg_mode;
              count_reg  <= '0;
              busy_reg   <= 1'b1;
              if (cfg_length == '0) begin
                state_reg <= DONE;
                done_reg  <= 1'b1;
              end else begin
                state_reg       <= SETUP;
                scan_enable_reg <= 1'b1;
              end
            end
          end
          SETUP: begin
            state_reg <= SHIFT;
          end
          SHIFT: begin
            if (last_shift) begin
              state_reg       <= DRAIN;
              scan_enable_reg <= 1'b0;
            end
          end
          DRAIN: begin
            if (drain_empty) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
          DONE: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
          default: begin
            state_reg       <= IDLE;
            busy_reg        <= 1'b0;
            scan_enable_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  // Serial input is forced to zero outside fire cycles so reset leaves the chains quiet.
  generate
    for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_scan_in
      assign scan_input[gi] = fire && (mode_reg ? strm.in_data[gi] : scan_output[gi]);
    end
  endgenerate

  assign busy           = busy_reg;
  assign done           = done_reg;
  assign shift_count    = count_reg;
  assign scan_enable    = scan_enable_reg;
  assign scan_ck_enable = fire;
  assign strm.in_ready  = fire && mode_reg;
  assign strm.out_valid = out_valid_reg;
  assign strm.out_data  = out_data_reg;

endmodule
